wb_ram_wb_ctrl: RTL and testbench
=================================

Name: wb_ram_wb_ctrl

Overview:
- Wishbone B3 slave front-end that sits directly upstream of the generic dual-address RAM.
- Turns bus cycles into RAM controls: byte write enables, write data, write address and read address. Returns RAM read data with ack/err.
- Supports classic cycles and incrementing bursts (linear, wrap4/8/16), so burst reads run at one beat per clock by pre-fetching the next address.

Parameters:
- depth, 256, RAM size in 32-bit words; power of two, at least 16.
- aw, 32, Wishbone byte-address width.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  aw  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  write strobe
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type (000 classic, 010 incr burst, 111 end of burst)
- wb_bte_i  in  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error (address out of range)
- wb_rty_o  out  1  tied 0
- ram_we_o  out  4  byte write enables to RAM
- ram_din_o  out  32  write data to RAM
- ram_waddr_o  out  $clog2(depth)  RAM write word address
- ram_raddr_o  out  $clog2(depth)  RAM read word address
- ram_dout_i  in  32  RAM read data (registered, 1-cycle latency)

Behaviour:
- Definitions:
  - AW = $clog2(depth).
  - word = wb_adr_i[AW+1:2].
  - oor = any bit of wb_adr_i[aw-1:AW+2] set.
  - valid = wb_cyc_i & wb_stb_i.
  - Low two address bits are ignored; wb_sel_i carries byte lanes.
- Registered state: wb_ack_o, wb_err_o, and FSM state {IDLE, BURST}. Async reset clears all three: ack=0, err=0, state=IDLE.
- Combinational outputs:
  - ram_we_o = wb_sel_i when (valid & wb_we_i & wb_ack_o), else 4'b0. Exactly one write per acked beat; 0 during reset.
  - ram_din_o = wb_dat_i.
  - ram_waddr_o = word.
  - wb_dat_o = ram_dout_i.
- Read address:
  - ram_raddr_o = next(word) when wb_ack_o & (wb_cti_i==010).
  - Otherwise ram_raddr_o = word.
- next():
  - bte 00: word+1 modulo depth (depth-1 wraps to 0).
  - bte 01: low 2 bits +1 mod 4, upper bits held.
  - bte 10: low 3 bits +1 mod 8.
  - bte 11: low 4 bits +1 mod 16.
- Ack/err next-state, evaluated each clock:
  - !valid: ack=0, err=0, state=IDLE.
  - valid & oor & !ack & !err: err=1 for one cycle, ack=0, no write, state=IDLE. Ends a burst too.
  - valid & !oor & !ack & !err: ack=1. state=BURST if cti==010, else IDLE.
  - valid & ack & cti==010: ack stays 1, state=BURST. One beat per clock.
  - valid & ack & cti!=010 (000, 111, reserved): ack=0, state=IDLE.
  - valid & err: err=0 (one-shot); re-evaluated next cycle.
- Latency:
  - Classic read or write: ack 1 cycle after valid, then ack low for at least 1 cycle.
  - Burst: first beat 1 wait state, subsequent beats 0 wait states.
- Master wait mid-burst (stb low): ack drops and state returns to IDLE. On resume, ram_raddr_o = word and there is 1 wait state, so no stale data is returned.
- Reserved cti codes are treated as classic.
- Reset asserted mid-burst: ack/err clear immediately (asynchronously) and ram_we_o goes 0 in the same instant. Release resumes in IDLE.

Decomposition:
- Shared wb_common package holds:
  - CTI_CLASSIC = 3'b000, CTI_INC = 3'b010, CTI_EOB = 3'b111.
  - BTE_LINEAR/BTE_WRAP4/BTE_WRAP8/BTE_WRAP16.
  - FSM state typedef.
- One sub-module, wb_burst_next_addr, implements the combinational next() function (parameter AW) and is reusable by other Wishbone slaves.
- Top instantiates this block plus wb_ram_generic.

Test Plan:
- Classic write then read: write adr 0x40, dat 0xDEADBEEF, sel 1111. Ack 1 cycle after stb; ram_we_o=1111 for exactly 1 cycle at word 0x10. Classic read of 0x40 returns 0xDEADBEEF with ack one cycle later, then ack low for 1 cycle.
- Byte lanes: write 0x11223344 with sel 0101 over a word holding 0xDEADBEEF. Readback = 0xDE22BE44.
- Linear burst read: preload words 0..7 = 0..7; read 8 beats from 0x0 with cti 010 x7 then 111. Acks on 8 consecutive clocks after one wait, data 0..7; ack low after the 111 beat.
- Wrap4 burst: start adr 0x08 (word 2), bte 01, 4 beats. Addresses/data are words 2,3,0,1. Wrap8 from word 6 gives 6,7,0..5. Linear burst from word depth-1 gives depth-1 then 0.
- Mid-burst stall and reset: deassert stb for 2 cycles at beat 3, resume → 1 wait, correct word 3, no duplicated write. Assert wb_rst_i during a burst write → ack and ram_we_o drop immediately; memory beyond the last acked beat is unchanged.
- Out-of-range: read or write at adr 0x0000_0400 with depth 256. err=1 for one cycle, ack=0, ram_we_o stays 0, RAM unchanged.

Source files
------------

// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes and the slave FSM state type.
package wb_common;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_burst_next_addr.sv
// Next word address of a Wishbone incrementing burst (linear or wrap4/8/16), combinational.
module wb_burst_next_addr
   import wb_common::*;
#(
   parameter int AW = 8
)(
   input  logic [AW-1:0] i_word,
   input  logic [1:0]    i_bte,
   output logic [AW-1:0] o_word
);

   // Wrapping modes only touch the low bits so the burst stays inside its aligned block
   always_comb begin
      o_word = i_word;
      case (i_bte)
         BTE_LINEAR: o_word = i_word + AW'(1);
         BTE_WRAP4:  o_word[1:0] = i_word[1:0] + 2'd1;
         BTE_WRAP8:  o_word[2:0] = i_word[2:0] + 3'd1;
         BTE_WRAP16: o_word[3:0] = i_word[3:0] + 4'd1;
         default:    o_word = i_word + AW'(1);
      endcase
   end

endmodule

// File: rtl/wb_ram_wb_ctrl.sv
// Wishbone B3 slave front-end for a dual-address RAM with registered (1-cycle) read data.
// Bursts pre-fetch the next address so reads after the first beat need no wait state.
module wb_ram_wb_ctrl
   import wb_common::*;
#(
   parameter int depth = 256,
   parameter int aw    = 32
)(
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [aw-1:0]            wb_adr_i,
   input  logic [31:0]              wb_dat_i,
   input  logic [3:0]               wb_sel_i,
   input  logic                     wb_we_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   input  logic [2:0]               wb_cti_i,
   input  logic [1:0]               wb_bte_i,
   output logic [31:0]              wb_dat_o,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic                     wb_rty_o,
   output logic [3:0]               ram_we_o,
   output logic [31:0]              ram_din_o,
   output logic [$clog2(depth)-1:0] ram_waddr_o,
   output logic [$clog2(depth)-1:0] ram_raddr_o,
   input  logic [31:0]              ram_dout_i
);

   localparam int AW = $clog2(depth);

   logic [AW-1:0] w_word;
   logic [AW-1:0] w_next;
   logic          w_oor;
   logic          w_valid;
   logic          w_inc;
   logic          w_unused_lsb;

   logic          r_ack;
   logic          r_err;
   wb_state_e     r_state;
   logic          w_ack_nxt;
   logic          w_err_nxt;
   wb_state_e     w_state_nxt;

   assign w_word       = wb_adr_i[AW+1:2];
   assign w_oor        = |wb_adr_i[aw-1:AW+2];
   assign w_valid      = wb_cyc_i & wb_stb_i;
   assign w_inc        = (wb_cti_i == CTI_INC);
   assign w_unused_lsb = ^wb_adr_i[1:0];

   wb_burst_next_addr #(.AW(AW)) u_next_addr (
      .i_word (w_word),
      .i_bte  (wb_bte_i),
      .o_word (w_next)
   );

   // Ack/err/state next-state; a zero-wait beat is only granted inside a burst started with an ack
   always_comb begin
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_state_nxt = ST_IDLE;
      if (!w_valid) begin
         w_state_nxt = ST_IDLE;
      end else if (r_err) begin
         w_err_nxt = 1'b0;
      end else if (r_ack) begin
         if (w_inc && (r_state == ST_BURST)) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_BURST;
         end else begin
            w_ack_nxt   = 1'b0;
         end
      end else if (w_oor) begin
         w_err_nxt = 1'b1;
      end else begin
         w_ack_nxt   = 1'b1;
         w_state_nxt = w_inc ? ST_BURST : ST_IDLE;
      end
   end

   // Handshake state register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_state <= ST_IDLE;
      end else begin
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_state <= w_state_nxt;
      end
   end

   // RAM controls: one write per acked beat, read address runs one beat ahead during bursts
   always_comb begin
      ram_we_o    = 4'b0000;
      ram_raddr_o = w_word;
      if (w_valid && wb_we_i && r_ack && !wb_rst_i) begin
         ram_we_o = wb_sel_i;
      end else begin
         ram_we_o = 4'b0000;
      end
      if (r_ack && w_inc) begin
         ram_raddr_o = w_next;
      end else begin
         ram_raddr_o = w_word;
      end
   end

   assign ram_din_o   = wb_dat_i;
   assign ram_waddr_o = w_word;
   assign wb_dat_o    = ram_dout_i;
   assign wb_ack_o    = r_ack;
   assign wb_err_o    = r_err;
   assign wb_rty_o    = 1'b0;

endmodule

// File: tb/tb_wb_ram_wb_ctrl.sv
// Self-checking bench for wb_ram_wb_ctrl with a behavioural 256-word RAM (registered read).
module tb_wb_ram_wb_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;
   logic        rty;
   logic [3:0]  ram_we;
   logic [31:0] ram_din;
   logic [7:0]  ram_waddr;
   logic [7:0]  ram_raddr;
   logic [31:0] ram_dout;

   logic        init;
   logic [31:0] mem [0:255];
   int          we_cnt;
   int          total;
   int          bad;
   logic [31:0] low_base;

   wb_ram_wb_ctrl #(.depth(256), .aw(32)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wb_adr_i    (adr),
      .wb_dat_i    (dat_w),
      .wb_sel_i    (sel),
      .wb_we_i     (we),
      .wb_cyc_i    (cyc),
      .wb_stb_i    (stb),
      .wb_cti_i    (cti),
      .wb_bte_i    (bte),
      .wb_dat_o    (dat_r),
      .wb_ack_o    (ack),
      .wb_err_o    (err),
      .wb_rty_o    (rty),
      .ram_we_o    (ram_we),
      .ram_din_o   (ram_din),
      .ram_waddr_o (ram_waddr),
      .ram_raddr_o (ram_raddr),
      .ram_dout_i  (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int w);
      return 32'h5A5A_0000 | 32'(w);
   endfunction

   // Expected RAM content: words 0..7 hold low_base|w, word 255 holds CAFEF00D, rest the init pattern
   function automatic logic [31:0] exp_data(input int w);
      if (w < 8) return low_base | 32'(w);
      else if (w == 255) return 32'hCAFE_F00D;
      else return pat(w);
   endfunction

   function automatic int model_next(input int w, input logic [1:0] b);
      int len;
      case (b)
         2'b01:   len = 4;
         2'b10:   len = 8;
         2'b11:   len = 16;
         default: len = 256;
      endcase
      return (w / len) * len + ((w % len) + 1) % len;
   endfunction

   always @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_waddr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
      ram_dout <= mem[ram_raddr];
   end

   always @(negedge clk) begin
      if (ram_we != 4'b0000) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        exp_err;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs [12];

   task automatic classic(input vec_t v, input int idx);
      int waits;
      int w0;
      logic got_ack;
      logic got_err;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat_w = v.dat; sel = v.sel;
      cti = 3'b000; bte = 2'b00;
      w0 = we_cnt;
      waits = 0; got_ack = 1'b0; got_err = 1'b0;
      while (!got_ack && !got_err && waits < 8) begin
         @(negedge clk);
         got_ack = ack; got_err = err;
         if (!got_ack && !got_err) waits++;
      end
      check($sformatf("classic%0d_waits", idx), 32'(waits), 32'd1);
      check($sformatf("classic%0d_ack", idx), {31'd0, got_ack}, {31'd0, !v.exp_err});
      check($sformatf("classic%0d_err", idx), {31'd0, got_err}, {31'd0, v.exp_err});
      if (!v.we && !v.exp_err) check($sformatf("classic%0d_dat", idx), dat_r, v.exp_dat);
      if (v.we && !v.exp_err) check($sformatf("classic%0d_waddr", idx), {24'd0, ram_waddr}, {24'd0, v.adr[9:2]});
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check($sformatf("classic%0d_ack_low", idx), {31'd0, ack}, 32'd0);
      check($sformatf("classic%0d_err_low", idx), {31'd0, err}, 32'd0);
      #1;
      check($sformatf("classic%0d_wecnt", idx), 32'(we_cnt - w0), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
   endtask

   task automatic burst(input string name, input int start_word, input logic [1:0] b,
                        input int n, input logic wr, input logic [31:0] wbase, input int stall_at);
      int beat;
      int cycles;
      int word;
      int w0;
      logic got;
      beat = 0; cycles = 0; word = start_word;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = wr; sel = 4'hF; bte = b;
      adr = 32'(word) << 2; dat_w = wbase | 32'(word);
      cti = (n == 1) ? 3'b111 : 3'b010;
      w0 = we_cnt;
      while (beat < n && cycles < 100) begin
         @(negedge clk);
         cycles++;
         got = ack && stb;
         if (got) begin
            if (!wr) check($sformatf("%s_beat%0d", name, beat), dat_r, exp_data(word));
            beat++;
            word = model_next(word, b);
         end
         @(posedge clk); #1;
         if (beat == n) begin
            cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
         end else if (got) begin
            adr = 32'(word) << 2; dat_w = wbase | 32'(word);
            cti = (beat == n - 1) ? 3'b111 : 3'b010;
            if (beat == stall_at) begin
               stb = 1'b0;
               repeat (2) begin @(negedge clk); cycles++; end
               @(posedge clk); #1;
               stb = 1'b1;
            end
         end
      end
      check({name, "_cycles"}, 32'(cycles), 32'(n + 1 + ((stall_at > 0) ? 3 : 0)));
      @(negedge clk);
      check({name, "_ack_low"}, {31'd0, ack}, 32'd0);
      #1;
      check({name, "_wecnt"}, 32'(we_cnt - w0), wr ? 32'(n) : 32'd0);
   endtask

   initial begin
      int acks;
      int cnt;
      int word;
      int w0;
      logic got;

      vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b1111, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'b0101, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b1111, 1'b0, 32'hDE22_BE44};
      vecs[4]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 4'b1111, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         4'b1111, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 1'b0, 32'h5A5A_0000};
      vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         4'b1111, 1'b0, 32'hCAFE_F00D};
      vecs[9]  = '{1'b0, 32'h0000_0044, 32'h0,         4'b1111, 1'b0, 32'h5A5A_0011};
      vecs[10] = '{1'b1, 32'h8000_0040, 32'h0BAD_0BAD, 4'b1111, 1'b1, 32'h0};
      vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,         4'b1111, 1'b0, 32'hDE22_BE44};

      total = 0; bad = 0; we_cnt = 0; low_base = 32'h0;
      rst = 1'b1; init = 1'b1;
      adr = 32'h0; dat_w = 32'h0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
      cti = 3'b000; bte = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ack", {31'd0, ack}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_rty", {31'd0, rty}, 32'd0);
      check("reset_we", {28'd0, ram_we}, 32'd0);
      @(posedge clk); #1;
      init = 1'b0; rst = 1'b0;

      for (int i = 0; i < 12; i++) classic(vecs[i], i);

      burst("preload", 0, 2'b00, 8, 1'b1, 32'h0, -1);
      burst("lin8", 0, 2'b00, 8, 1'b0, 32'h0, -1);
      burst("wrap4", 2, 2'b01, 4, 1'b0, 32'h0, -1);
      burst("wrap8", 6, 2'b10, 8, 1'b0, 32'h0, -1);
      burst("wrap16", 14, 2'b11, 4, 1'b0, 32'h0, -1);
      burst("lin_top", 255, 2'b00, 2, 1'b0, 32'h0, -1);

      burst("stall_wr", 0, 2'b00, 8, 1'b1, 32'h7700_0000, 3);
      low_base = 32'h7700_0000;
      burst("stall_rd", 0, 2'b00, 8, 1'b0, 32'h0, 3);

      // Reset in the middle of a burst write to words 8..: three beats land, the fourth must not
      @(posedge clk); #1;
      word = 8;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = 2'b00; cti = 3'b010;
      adr = 32'(word) << 2; dat_w = 32'hBB00_0000 | 32'(word);
      w0 = we_cnt; acks = 0; cnt = 0;
      while (acks < 3 && cnt < 20) begin
         @(negedge clk);
         cnt++;
         got = ack;
         if (got) begin acks++; word++; end
         @(posedge clk); #1;
         if (got) begin adr = 32'(word) << 2; dat_w = 32'hBB00_0000 | 32'(word); end
      end
      check("rst_acks", 32'(acks), 32'd3);
      check("rst_pre_we", {28'd0, ram_we}, 32'h0000_000F);
      #1 rst = 1'b1;
      #1;
      check("rst_ack_drop", {31'd0, ack}, 32'd0);
      check("rst_we_drop", {28'd0, ram_we}, 32'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_ack", {31'd0, ack}, 32'd0);
      check("rst_release_err", {31'd0, err}, 32'd0);
      #1;
      check("rst_wecnt", 32'(we_cnt - w0), 32'd3);
      classic('{1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b0, 32'hBB00_0009}, 20);
      classic('{1'b0, 32'h0000_0028, 32'h0, 4'hF, 1'b0, 32'hBB00_000A}, 21);
      classic('{1'b0, 32'h0000_002C, 32'h0, 4'hF, 1'b0, 32'h5A5A_000B}, 22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
